ks_adder_pipe: RTL
==================

// Module: ks_adder_pipe
// PURPOSE
//  Parametrised, fully pipelined Kogge-Stone adder/subtractor for the information-flow analysis datapath.
//  Supersedes the single-bit prefix PE: one registered prefix level per pipeline stage, WIDTH-bit operands.
//  Adds a valid/ready stream handshake, global stall, add/sub mode, carry/overflow flags and a per-beat tag.
//  Sticky FINISH freeze: input closes, the pipeline drains, DONE is raised.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits, >=2, any value (not required to be a power of 2)
//  TAG_W   4   width of the opaque tag carried alongside each operation, >=1
//  LEVELS  (derived, localparam) $clog2(WIDTH); number of prefix stages
// PORTS
//  CLK        in   1       clock, all state updates on posedge
//  RST        in   1       synchronous, active-high reset
//  IN_VALID   in   1       operand beat valid
//  IN_READY   out  1       block accepts a beat this cycle
//  A          in   WIDTH   operand A
//  B          in   WIDTH   operand B
//  CIN        in   1       carry-in; ignored when SUB=1
//  SUB        in   1       1: A-B (B inverted, carry-in forced to 1); 0: A+B+CIN
//  TAG        in   TAG_W   passed unchanged to OUT_TAG
//  FINISH     in   1       request freeze (sampled every cycle, sticky)
//  OUT_VALID  out  1       result beat valid
//  OUT_READY  in   1       consumer accepts the result
//  SUM        out  WIDTH   result
//  COUT       out  1       carry out of bit WIDTH-1 (SUB: 1 = no borrow)
//  OVF        out  1       signed overflow = carry into MSB ^ COUT
//  OUT_TAG    out  TAG_W   tag of the result beat
//  DONE       out  1       frozen and pipeline empty
// BEHAVIOUR
//  - Reset: every stage valid bit=0; SUM, COUT, OVF, OUT_TAG, OUT_VALID, DONE=0; frozen flag=0.
//    RST mid-operation discards all in-flight beats in the same edge; no partial result is emitted.
//  - Pipeline: S0 pre-process (b'=SUB?~B:B, c0=SUB|CIN, g=A&b', p=A^b', carry-in as g[-1]),
//    S1..S_LEVELS prefix levels with distance d=2^(k-1): G[i]|=P[i]&G[i-d], P[i]&=P[i-d] (i-d>=-1),
//    i-d<-1: pass through. Final stage: SUM[i]=p[i]^Gc[i-1] (Gc[-1]=c0), COUT=Gc[WIDTH-1].
//    Latency = LEVELS+2 cycles from accept to OUT_VALID with no stall (WIDTH=16 -> 6).
//  - Throughput: 1 beat/cycle. Each stage carries its own valid bit; bubbles propagate and never emit.
//  - Stall: adv = !OUT_VALID | OUT_READY. When adv=0 every stage holds (global stall, no skid).
//    IN_READY = adv & !frozen. Beat accepted iff IN_VALID & IN_READY.
//  - Output hold: while OUT_VALID & !OUT_READY, SUM/COUT/OVF/OUT_TAG are stable.
//  - FINISH: frozen<=1 on any cycle FINISH=1 (sticky until RST). IN_READY drops the cycle after FINISH
//    is sampled; a beat accepted in the same cycle FINISH is first high is kept and completes.
//    In-flight beats drain under normal handshake. DONE=1 registered, one cycle after frozen & all stage valids=0;
//    DONE holds until RST.
//  - Simultaneous accept + output stall impossible by construction (IN_READY depends on adv).
//  - Arithmetic modulo 2^WIDTH; no saturation. OVF meaningful for two's-complement operands.
// STRUCTURE
//  - Package ks_pkg: function ks_levels(width)=$clog2(width); typedef for the stage bundle
//    {valid, g, p, c0, tag} parametrised via macros on WIDTH/TAG_W.
//  - One sub-module: ks_prefix_stage #(WIDTH, DIST, TAG_W): one registered prefix level with enable=adv;
//    instantiated LEVELS times by a generate loop. Pre-process and sum stages live in the top.
// TESTING (WIDTH=16, TAG_W=4 unless stated)
//  1. A=0xFFFF,B=0x0001,CIN=0,SUB=0,TAG=3 -> after 6 cycles SUM=0x0000,COUT=1,OVF=0,OUT_TAG=3.
//  2. SUB: A=0x0005,B=0x0007 -> SUM=0xFFFE,COUT=0,OVF=0; A=0x8000,B=0x0001 -> SUM=0x7FFF,COUT=1,OVF=1.
//  3. A=0x7FFF,B=0x0001,CIN=0 -> SUM=0x8000,COUT=0,OVF=1; CIN=1 on A=B=0 -> SUM=0x0001.
//  4. Stream 20 random beats back-to-back, OUT_READY toggled randomly -> results in order, tags match,
//     outputs stable while stalled, no loss/duplication vs golden model.
//  5. 3 beats in flight, assert FINISH 1 cycle -> IN_READY=0 next cycle, 3 results emitted, DONE=1
//     one cycle after last OUT_VALID handshake, stays 1 until RST.
//  6. RST asserted with pipeline full and OUT_READY=0 -> next cycle OUT_VALID=0, DONE=0, IN_READY=1;
//     repeat 1 with WIDTH=5 (LEVELS=3): A=0x1F,B=0x01 -> SUM=0x00,COUT=1 after 5 cycles.

Source files
------------

// File: rtl/ks_adder_pipe_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder/subtractor.
// The stage bundle is a macro so each module can instantiate it for its
// own WIDTH/TAG_W. Bits, MSB first:
//   valid | g | p | hs | c0 | tag
// g/p are the group generate/propagate being merged level by level.
// hs is the untouched per-bit half-sum, which the sum stage needs.
// c0 is the effective carry-in.

`ifndef KS_STAGE_T
`define KS_STAGE_T(W, TW) struct packed { logic valid; logic [(W)-1:0] g; logic [(W)-1:0] p; logic [(W)-1:0] hs; logic c0; logic [(TW)-1:0] tag; }
`endif

package ks_pkg;

  // number of prefix levels needed to span WIDTH bits
  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

  // flattened width of one stage bundle
  function automatic int ks_stage_bits(input int width, input int tag_w);
    return 3 * width + 2 + tag_w;
  endfunction

  // merge distance of prefix level k (k starts at 1)
  function automatic int ks_dist(input int level);
    return 1 << (level - 1);
  endfunction

endpackage

// File: rtl/ks_adder_pipe_prefix.sv
// One registered Kogge-Stone prefix level.
// Bit i merges with bit i-DIST.
// Bits below DIST already hold their full group from bit 0 and pass through unchanged.
// The stage holds whenever adv is low.

module ks_prefix_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  parameter int TAG_W = 4,
  localparam int STG_W = ks_stage_bits(WIDTH, TAG_W)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             adv,
  input  logic [STG_W-1:0] stage_in,
  output logic [STG_W-1:0] stage_out
);

  typedef `KS_STAGE_T(WIDTH, TAG_W) stage_t;

  stage_t           cur;
  stage_t           q;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;

  assign cur = stage_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_merge
      assign g_nxt[i] = cur.g[i] | (cur.p[i] & cur.g[i-DIST]);
      assign p_nxt[i] = cur.p[i] & cur.p[i-DIST];
    end else begin : g_pass
      assign g_nxt[i] = cur.g[i];
      assign p_nxt[i] = cur.p[i];
    end
  end

  // register the merged level; everything freezes while the output is stalled
  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (adv) begin
      q.valid <= cur.valid;
      q.g     <= g_nxt;
      q.p     <= p_nxt;
      q.hs    <= cur.hs;
      q.c0    <= cur.c0;
      q.tag   <= cur.tag;
    end
  end

  assign stage_out = q;

endmodule

// File: rtl/ks_adder_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with a valid/ready stream.
// Pipeline:
//   - S0 conditions the operands.
//   - LEVELS prefix stages follow.
//   - An output register resolves the carries.
// One global advance enable stalls every stage at once (no skid buffer).
// FINISH closes the input for good.
// Once the pipe has drained, DONE latches high until reset.

module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  input  logic [TAG_W-1:0] TAG,
  input  logic             FINISH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             DONE
);

  localparam int LEVELS = ks_levels(WIDTH);
  localparam int STG_W  = ks_stage_bits(WIDTH, TAG_W);

  typedef `KS_STAGE_T(WIDTH, TAG_W) stage_t;

  logic             adv;
  logic             accept;
  logic             frozen;
  logic             busy;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] gc;
  logic [WIDTH-1:0] sum_nxt;
  logic [LEVELS:0]  stage_valid;
  logic [STG_W-1:0] stg [0:LEVELS];
  stage_t           pre;
  stage_t           s0_q;
  stage_t           last;

  assign adv      = !OUT_VALID | OUT_READY;
  assign IN_READY = adv & !frozen;
  assign accept   = IN_VALID & IN_READY;

  // operand conditioning: subtract as A + ~B + 1, carry-in ignored
  always_comb begin
    b_eff     = SUB ? ~B : B;
    pre       = '0;
    pre.valid = accept;
    pre.g     = A & b_eff;
    pre.p     = A ^ b_eff;
    pre.hs    = A ^ b_eff;
    pre.c0    = SUB | CIN;
    pre.tag   = TAG;
  end

  // S0 register; a bubble enters whenever no beat is accepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_q <= '0;
    end else if (adv) begin
      s0_q <= pre;
    end
  end

  assign stg[0] = s0_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ks_prefix_stage #(
      .WIDTH (WIDTH),
      .DIST  (ks_dist(k)),
      .TAG_W (TAG_W)
    ) u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .adv       (adv),
      .stage_in  (stg[k-1]),
      .stage_out (stg[k])
    );
  end

  // valid is the MSB of each flattened bundle
  for (genvar k = 0; k <= LEVELS; k++) begin : g_valid
    assign stage_valid[k] = stg[k][STG_W-1];
  end

  assign last = stg[LEVELS];
  assign busy = (|stage_valid) | OUT_VALID;

  // Carry-in is folded in last.
  // After the prefix levels, g/p describe the group from bit 0 up to bit i.
  // So the carry out of bit i is G | P & c0.
  always_comb begin
    gc      = last.g | (last.p & {WIDTH{last.c0}});
    sum_nxt = last.hs ^ {gc[WIDTH-2:0], last.c0};
  end

  // result register; data only moves on a real beat so a stalled result stays put
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      SUM       <= '0;
      COUT      <= 1'b0;
      OVF       <= 1'b0;
      OUT_TAG   <= '0;
    end else if (adv) begin
      OUT_VALID <= last.valid;
      if (last.valid) begin
        SUM     <= sum_nxt;
        COUT    <= gc[WIDTH-1];
        OVF     <= gc[WIDTH-1] ^ gc[WIDTH-2];
        OUT_TAG <= last.tag;
      end
    end
  end

  // sticky freeze and drain-complete flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      frozen <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      if (FINISH) begin
        frozen <= 1'b1;
      end
      if (frozen & !busy) begin
        DONE <= 1'b1;
      end
    end
  end

endmodule
